// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment patterns,
// anode enables and the scan-slot encoding.
package seg_pkg;

    localparam int unsigned NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        SlotOnes  = 2'd0,
        SlotTens  = 2'd1,
        SlotHunds = 2'd2,
        SlotDark  = 2'd3
    } slot_e;

    // Active-low, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_ONES  = 4'b1110;
    localparam logic [3:0] AN_TENS  = 4'b1101;
    localparam logic [3:0] AN_HUNDS = 4'b1011;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    function automatic slot_e next_slot(input slot_e i_slot);
        return slot_e'(i_slot + 2'd1);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-decimal nibbles
// render as a dash, and i_blank forces all segments off.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_nibble)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-slot multiplexed driver for a 3-digit BCD value; updates are shadowed and only
// committed at the frame boundary so a digit never tears mid-scan.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    input  logic        blank_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    slot_e            r_slot, w_slot_d;
    logic [11:0]      r_shadow, w_shadow_d;
    logic [11:0]      r_disp, w_disp_d;
    logic             r_pending, w_pending_d;
    logic             w_wrap;
    logic [3:0]       r_an, w_an_d;
    logic [6:0]       r_seg, w_seg_d;
    logic [3:0]       w_nibble;
    logic             w_blank;

    always_comb begin
        w_cnt_d     = r_cnt + CNT_W'(1);
        w_slot_d    = r_slot;
        w_shadow_d  = r_shadow;
        w_disp_d    = r_disp;
        w_pending_d = r_pending;
        w_wrap      = 1'b0;
        if (r_cnt == CNT_MAX) begin
            w_cnt_d  = '0;
            w_slot_d = next_slot(r_slot);
            w_wrap   = (r_slot == SlotDark);
        end
        if (bcd_valid) begin
            w_shadow_d  = bcd_in;
            w_pending_d = 1'b1;
        end
        // A strobe landing on the commit edge goes straight to the display
        if (w_wrap) begin
            if (bcd_valid) begin
                w_disp_d    = bcd_in;
                w_pending_d = 1'b0;
            end else if (r_pending) begin
                w_disp_d    = r_shadow;
                w_pending_d = 1'b0;
            end
        end
    end

    always_comb begin
        w_an_d   = AN_OFF;
        w_nibble = r_disp[3:0];
        w_blank  = 1'b1;
        unique case (r_slot)
            SlotOnes: begin
                w_an_d   = AN_ONES;
                w_nibble = r_disp[3:0];
                w_blank  = 1'b0;
            end
            SlotTens: begin
                w_an_d   = AN_TENS;
                w_nibble = r_disp[7:4];
                w_blank  = blank_en && (r_disp[11:8] == 4'd0) && (r_disp[7:4] == 4'd0);
            end
            SlotHunds: begin
                w_an_d   = AN_HUNDS;
                w_nibble = r_disp[11:8];
                w_blank  = blank_en && (r_disp[11:8] == 4'd0);
            end
            SlotDark: begin
                w_an_d  = AN_OFF;
                w_blank = 1'b1;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .o_seg    (w_seg_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_slot    <= SlotOnes;
            r_shadow  <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
            r_an      <= AN_OFF;
            r_seg     <= SEG_BLANK;
        end else begin
            r_cnt     <= w_cnt_d;
            r_slot    <= w_slot_d;
            r_shadow  <= w_shadow_d;
            r_disp    <= w_disp_d;
            r_pending <= w_pending_d;
            r_an      <= w_an_d;
            r_seg     <= w_seg_d;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule
